image_sequence_fsm: RTL and testbench

//  Parametrised multi-A-line transmit sequencer; successor to the fixed 16-A-line image FSM.

---
 rtl/image_sequence_fsm.sv | 255 +++++++++++++++++++++++++
 tb/tb_image_sequence_fsm.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_sequence_fsm.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// image_sequence_fsm
//
// Purpose:
//   Multi-A-line transmit sequencer. It walks A-lines 0..num_alines-1 and
//   fires each one (num_repeats+1) times for averaging. For every A-line it
//   first fetches the delay set from config storage, then pulses the A-line
//   transmitter once per firing. It waits for acquisition memory to drain
//   before moving to the next A-line. Abort returns to IDLE from any state.
//
// Optional feature (macro PRF_TIMER_EN):
//   When defined, a PRF interval timer is inserted between repeated firings
//   of the same A-line. The parameter PRF_W and the port prf_interval exist
//   only in that build. When undefined, repeats go straight back to ARM and
//   the PRF_WAIT state is unreachable.
//
// Parameters:
//   ALINE_W  width of A-line count / index
//   REP_W    width of repeat count
//   PRF_W    width of PRF interval counter (PRF_TIMER_EN only)
//
// Ports:
//   clk                  system clock, all logic on posedge
//   rst_n                synchronous active-low reset
//   start                level, sampled in IDLE
//   abort                level, returns to IDLE from any state
//   num_alines           A-lines per image, latched at start
//   num_repeats          extra firings per A-line, latched at start
//   cfg_busy             config storage is taking UART data
//   cfg_rd_req           delay fetch request (held through FETCH)
//   cfg_rd_addr          A-line index to fetch
//   cfg_rd_ack           delays loaded into transmitter
//   tx_start             one-cycle pulse to the A-line transmitter
//   tx_done              one-cycle pulse, firing complete
//   mem_clear            acquisition memory drained
//   prf_interval         min spacing tx_done -> next tx_start (PRF_TIMER_EN)
//   busy                 any non-IDLE state, or cfg_busy while IDLE
//   transmit_in_progress any non-IDLE state
//   done                 one-cycle pulse on normal completion
//   current_state        IDLE=0 FETCH=1 ARM=2 WAIT_TX=3 WAIT_MEM=4 PRF_WAIT=5
//   current_aline        A-line index in progress
//   current_repeat       firing index within the current A-line
// ---------------------------------------------------------------------------
module image_sequence_fsm #(
    parameter int ALINE_W = 4,
    parameter int REP_W   = 4
`ifdef PRF_TIMER_EN
    ,
    parameter int PRF_W   = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [ALINE_W-1:0] num_alines,
    input  logic [REP_W-1:0]   num_repeats,
    input  logic               cfg_busy,
    output logic               cfg_rd_req,
    output logic [ALINE_W-1:0] cfg_rd_addr,
    input  logic               cfg_rd_ack,
    output logic               tx_start,
    input  logic               tx_done,
    input  logic               mem_clear,
`ifdef PRF_TIMER_EN
    input  logic [PRF_W-1:0]   prf_interval,
`endif
    output logic               busy,
    output logic               transmit_in_progress,
    output logic               done,
    output logic [2:0]         current_state,
    output logic [ALINE_W-1:0] current_aline,
    output logic [REP_W-1:0]   current_repeat
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        ARM      = 3'd2,
        WAIT_TX  = 3'd3,
        WAIT_MEM = 3'd4,
        PRF_WAIT = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ALINE_W-1:0] r_aline;
    logic [ALINE_W-1:0] w_aline_next;
    logic [REP_W-1:0]   r_rep;
    logic [REP_W-1:0]   w_rep_next;
    logic [ALINE_W-1:0] r_num_alines;
    logic [ALINE_W-1:0] w_num_alines_next;
    logic [REP_W-1:0]   r_num_repeats;
    logic [REP_W-1:0]   w_num_repeats_next;
    logic               w_done_next;

    logic               r_cfg_rd_req;
    logic               r_tx_start;
    logic               r_busy;
    logic               r_tip;
    logic               r_done;

`ifdef PRF_TIMER_EN
    logic [PRF_W-1:0]   r_prf_cnt;
    logic [PRF_W-1:0]   w_prf_cnt_next;
`endif

    // One extra bit so that aline+1 at the maximum count does not wrap to 0
    // and falsely look like "more A-lines remain".
    logic [ALINE_W:0]   w_aline_inc;
    logic               w_more_alines;
    logic               w_more_reps;

    assign w_aline_inc   = {1'b0, r_aline} + {{ALINE_W{1'b0}}, 1'b1};
    assign w_more_alines = (w_aline_inc < {1'b0, r_num_alines});
    assign w_more_reps   = (r_rep < r_num_repeats);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_aline       <= '0;
            r_rep         <= '0;
            r_num_alines  <= '0;
            r_num_repeats <= '0;
        end else begin
            r_state       <= w_state_next;
            r_aline       <= w_aline_next;
            r_rep         <= w_rep_next;
            r_num_alines  <= w_num_alines_next;
            r_num_repeats <= w_num_repeats_next;
        end
    end

`ifdef PRF_TIMER_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prf_cnt <= '0;
        end else begin
            r_prf_cnt <= w_prf_cnt_next;
        end
    end
`endif

    // Next-state and datapath logic
    always_comb begin
        w_state_next       = r_state;
        w_aline_next       = r_aline;
        w_rep_next         = r_rep;
        w_num_alines_next  = r_num_alines;
        w_num_repeats_next = r_num_repeats;
        w_done_next        = 1'b0;
`ifdef PRF_TIMER_EN
        w_prf_cnt_next     = r_prf_cnt;
`endif

        if (abort) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !cfg_busy && (num_alines != '0)) begin
                        w_num_alines_next  = num_alines;
                        w_num_repeats_next = num_repeats;
                        w_aline_next       = '0;
                        w_rep_next         = '0;
                        w_state_next       = FETCH;
                    end
                end
                FETCH: begin
                    if (cfg_rd_ack) begin
                        w_state_next = ARM;
                    end
                end
                ARM: begin
                    w_state_next = WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        if (w_more_reps) begin
                            // Same A-line again: delays are still loaded.
                            w_rep_next = r_rep + REP_W'(1);
`ifdef PRF_TIMER_EN
                            w_prf_cnt_next = prf_interval;
                            w_state_next   = PRF_WAIT;
`else
                            w_state_next   = ARM;
`endif
                        end else begin
                            w_state_next = WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_clear) begin
                        if (w_more_alines) begin
                            w_aline_next = w_aline_inc[ALINE_W-1:0];
                            w_rep_next   = '0;
                            w_state_next = FETCH;
                        end else begin
                            w_done_next  = 1'b1;
                            w_state_next = IDLE;
                        end
                    end
                end
                PRF_WAIT: begin
`ifdef PRF_TIMER_EN
                    // Interval 0 still spends one cycle here.
                    if (r_prf_cnt == '0) begin
                        w_state_next = ARM;
                    end else begin
                        w_prf_cnt_next = r_prf_cnt - PRF_W'(1);
                    end
`else
                    w_state_next = IDLE;
`endif
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the
    // state register: e.g. tx_start is high exactly while the FSM is in ARM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg_rd_req <= 1'b0;
            r_tx_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_tip        <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_cfg_rd_req <= (w_state_next == FETCH);
            r_tx_start   <= (w_state_next == ARM);
            r_busy       <= (w_state_next != IDLE) || cfg_busy;
            r_tip        <= (w_state_next != IDLE);
            r_done       <= w_done_next;
        end
    end

    assign cfg_rd_req           = r_cfg_rd_req;
    assign cfg_rd_addr          = r_aline;
    assign tx_start             = r_tx_start;
    assign busy                 = r_busy;
    assign transmit_in_progress = r_tip;
    assign done                 = r_done;
    assign current_state        = r_state;
    assign current_aline        = r_aline;
    assign current_repeat       = r_rep;

endmodule

// File: tb/tb_image_sequence_fsm.sv
`timescale 1ns/1ps
// Testbench for image_sequence_fsm. A responder answers fetch, transmit and
// memory-drain handshakes two cycles after they are requested; a scoreboard
// queue holds the expected fetch / tx_start / done events of each image.
module tb_image_sequence_fsm;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] num_alines;
    logic [3:0] num_repeats;
    logic       cfg_busy;
    logic       cfg_rd_req;
    logic [3:0] cfg_rd_addr;
    logic       cfg_rd_ack;
    logic       tx_start;
    logic       tx_done;
    logic       mem_clear;
    logic [15:0] prf_interval;
    logic       busy;
    logic       transmit_in_progress;
    logic       done;
    logic [2:0] current_state;
    logic [3:0] current_aline;
    logic [3:0] current_repeat;

    image_sequence_fsm dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .abort                (abort),
        .num_alines           (num_alines),
        .num_repeats          (num_repeats),
        .cfg_busy             (cfg_busy),
        .cfg_rd_req           (cfg_rd_req),
        .cfg_rd_addr          (cfg_rd_addr),
        .cfg_rd_ack           (cfg_rd_ack),
        .tx_start             (tx_start),
        .tx_done              (tx_done),
        .mem_clear            (mem_clear),
`ifdef PRF_TIMER_EN
        .prf_interval         (prf_interval),
`endif
        .busy                 (busy),
        .transmit_in_progress (transmit_in_progress),
        .done                 (done),
        .current_state        (current_state),
        .current_aline        (current_aline),
        .current_repeat       (current_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Event = {type, aline, repeat}; type 1=fetch, 2=tx_start, 3=done
    logic [11:0] exp_q[$];

    function automatic logic [11:0] ev(input logic [3:0] t, input logic [3:0] a, input logic [3:0] r);
        return {t, a, r};
    endfunction

    task automatic push_image(input int na, input int nr);
        for (int a = 0; a < na; a++) begin
            exp_q.push_back(ev(4'd1, 4'(a), 4'd0));
            for (int r = 0; r <= nr; r++) begin
                exp_q.push_back(ev(4'd2, 4'(a), 4'(r)));
            end
        end
        exp_q.push_back(ev(4'd3, 4'd0, 4'd0));
    endtask

    task automatic expect_event(input logic [11:0] e);
        if (exp_q.size() == 0) begin
            check("unexpected_event", {20'd0, e}, 32'd0);
        end else begin
            check("event", {20'd0, e}, {20'd0, exp_q.pop_front()});
        end
        $display("event type=%0d aline=%0d rep=%0d", e[11:8], e[7:4], e[3:0]);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    int   cyc = 0;
    int   last_tx_cyc = 0;
    logic prev_req = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (cfg_rd_req && !prev_req) expect_event(ev(4'd1, cfg_rd_addr, 4'd0));
            if (cfg_rd_req) check("rd_addr", {28'd0, cfg_rd_addr}, {28'd0, current_aline});
            if (tx_start) begin
                expect_event(ev(4'd2, current_aline, current_repeat));
                if (current_repeat != 4'd0) begin
`ifdef PRF_TIMER_EN
                    check("prf_gap_ok", {31'd0, ((cyc - last_tx_cyc) >= (int'(prf_interval) + 2))}, 32'd1);
`else
                    check("rep_gap", cyc - last_tx_cyc, 32'd3);
`endif
                end
                last_tx_cyc = cyc;
            end
            if (done) expect_event(ev(4'd3, 4'd0, 4'd0));
            prev_req = cfg_rd_req;
        end
    end

    // Responder: ack, tx_done and mem_clear two cycles after each request
    int ack_cnt = 0;
    int tx_cnt  = 0;
    int mem_cnt = 0;
    initial begin
        cfg_rd_ack = 1'b0;
        tx_done    = 1'b0;
        mem_clear  = 1'b0;
        forever begin
            @(negedge clk);
            cfg_rd_ack = 1'b0;
            tx_done    = 1'b0;
            mem_clear  = 1'b0;
            if (cfg_rd_req) begin
                ack_cnt++;
                if (ack_cnt == 2) begin
                    cfg_rd_ack = 1'b1;
                    ack_cnt    = 0;
                end
            end else begin
                ack_cnt = 0;
            end
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) tx_done = 1'b1;
            end
            if (tx_start) tx_cnt = 2;
            if (current_state == 3'd4) begin
                mem_cnt++;
                if (mem_cnt == 2) begin
                    mem_clear = 1'b1;
                    mem_cnt   = 0;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int i = 0;
        while (current_state !== s && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, {29'd0, current_state}, {29'd0, s});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, {29'd0, current_state}, 32'd0);
        check({tag, "_req"},   {31'd0, cfg_rd_req}, 32'd0);
        check({tag, "_tx"},    {31'd0, tx_start}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_tip"},   {31'd0, transmit_in_progress}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_aline"}, {28'd0, current_aline}, 32'd0);
        check({tag, "_rep"},   {28'd0, current_repeat}, 32'd0);
        check({tag, "_addr"},  {28'd0, cfg_rd_addr}, 32'd0);
    endtask

    task automatic run_image(input int na, input int nr, input string tag);
        push_image(na, nr);
        num_alines  = 4'(na);
        num_repeats = 4'(nr);
        start       = 1'b1;
        wait_state(3'd1, 10, {tag, "_enter_fetch"});
        start = 1'b0;
        wait_state(3'd0, 2000, {tag, "_back_idle"});
        @(negedge clk);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        num_alines   = 4'd0;
        num_repeats  = 4'd0;
        cfg_busy     = 1'b0;
        prf_interval = 16'd10;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Three A-lines, single firing each
        run_image(3, 0, "img3x0");

        // Two A-lines, four firings each
        run_image(2, 3, "img2x3");

        // num_alines == 0 is ignored
        num_alines = 4'd0;
        start      = 1'b1;
        repeat (10) @(negedge clk);
        check("zero_state", {29'd0, current_state}, 32'd0);
        check("zero_tip", {31'd0, transmit_in_progress}, 32'd0);
        check("zero_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;

        // cfg_busy blocks start but shows as busy
        cfg_busy   = 1'b1;
        num_alines = 4'd2;
        start      = 1'b1;
        repeat (4) @(negedge clk);
        check("cfgbusy_busy", {31'd0, busy}, 32'd1);
        check("cfgbusy_state", {29'd0, current_state}, 32'd0);
        check("cfgbusy_tip", {31'd0, transmit_in_progress}, 32'd0);
        cfg_busy = 1'b0;
        start    = 1'b0;
        @(negedge clk);

        // Abort in WAIT_TX at A-line 1
        exp_q.push_back(ev(4'd1, 4'd0, 4'd0));
        exp_q.push_back(ev(4'd2, 4'd0, 4'd0));
        exp_q.push_back(ev(4'd1, 4'd1, 4'd0));
        exp_q.push_back(ev(4'd2, 4'd1, 4'd0));
        num_alines  = 4'd3;
        num_repeats = 4'd0;
        start       = 1'b1;
        wait_state(3'd1, 10, "abort_enter_fetch");
        start = 1'b0;
        i = 0;
        while (!(current_state == 3'd3 && current_aline == 4'd1) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("abort_reach_wait_tx", {25'd0, current_state, current_aline}, {25'd0, 3'd3, 4'd1});
        abort = 1'b1;
        @(negedge clk);
        check("abort_state", {29'd0, current_state}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_tx", {31'd0, tx_start}, 32'd0);
        check("abort_req", {31'd0, cfg_rd_req}, 32'd0);
        check("abort_tip", {31'd0, transmit_in_progress}, 32'd0);
        abort = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_stay_idle", {29'd0, current_state}, 32'd0);
        check("abort_queue_empty", exp_q.size(), 32'd0);

        // Start held through done: a new image starts on the following cycle
        push_image(1, 0);
        push_image(1, 0);
        num_alines  = 4'd1;
        num_repeats = 4'd0;
        start       = 1'b1;
        i = 0;
        while (done !== 1'b1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("held_done_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("held_restart_fetch", {29'd0, current_state}, 32'd1);
        start = 1'b0;
        wait_state(3'd0, 200, "held_back_idle");
        @(negedge clk);
        check("held_queue_empty", exp_q.size(), 32'd0);

        // Reset in WAIT_MEM
        exp_q.push_back(ev(4'd1, 4'd0, 4'd0));
        exp_q.push_back(ev(4'd2, 4'd0, 4'd0));
        num_alines  = 4'd1;
        num_repeats = 4'd2;
        start       = 1'b1;
        wait_state(3'd1, 10, "rst_enter_fetch");
        start = 1'b0;
        // repeats would add events; set num_repeats=2 was latched, so extend queue
        exp_q.push_back(ev(4'd2, 4'd0, 4'd1));
        exp_q.push_back(ev(4'd2, 4'd0, 4'd2));
        wait_state(3'd4, 200, "rst_reach_wait_mem");
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_queue_empty", exp_q.size(), 32'd0);

        // Maximum A-line count must not wrap
        run_image(15, 0, "img15");
        check("img15_last_aline", {28'd0, current_aline}, 32'd14);

`ifdef PRF_TIMER_EN
        prf_interval = 16'd10;
        run_image(1, 1, "prf");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
